// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter sharing one RAM; one transaction at a time, ack pulses one cycle after completion.
// Optional read timeout enabled by defining RAM_ARB_TIMEOUT_EN (err + all-ones rdata after TIMEOUT wait cycles).
module ram_arbiter #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_rready
);

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, DONE} state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..255");
    end

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               gnt_q, gnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
`ifdef RAM_ARB_TIMEOUT_EN
    logic               err_q, err_d;
    logic [7:0]         cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef RAM_ARB_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester not served last wins
                    gnt_d   = (req == 2'b11) ? ~last_q : req[1];
                    last_d  = gnt_d;
                    addr_d  = gnt_d ? addr1 : addr0;
                    wdata_d = gnt_d ? wdata1 : wdata0;
                    state_d = we[gnt_d] ? WRITE : READ_WAIT;
`ifdef RAM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
`endif
                end
            end
            WRITE: state_d = DONE;
            READ_WAIT: begin
                if (ram_rready) begin
                    rdata_d = ram_rdata;
                    state_d = DONE;
                end
`ifdef RAM_ARB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
`ifdef RAM_ARB_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef RAM_ARB_TIMEOUT_EN
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign ram_write = (state_q == WRITE);
    assign ram_read  = (state_q == READ_WAIT);
    assign ram_waddr = addr_q;
    assign ram_raddr = addr_q;
    assign ram_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign ack       = (state_q == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
`ifdef RAM_ARB_TIMEOUT_EN
    assign err       = (state_q == DONE) && err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level reference model checked every cycle plus directed literal checks.
module tb_ram_arbiter;
    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req, we, ack;
    logic [ADDR_W-1:0] addr0, addr1, ram_raddr, ram_waddr;
    logic [DATA_W-1:0] wdata0, wdata1, rdata, ram_wdata, ram_rdata;
    logic              err, ram_read, ram_write, ram_rready;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata(rdata), .err(err),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_rready(ram_rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: walks one transaction at a time and publishes what each output must be
    logic [1:0]        e_ack;
    logic              e_err, e_rd, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_rdata;
    bit                m_valid = 1'b0;
    int                m_last;

    task automatic m_edge(output bit r);
        @(posedge clk);
        r = reset;
        if (reset) begin
            e_ack = 2'b00; e_err = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
            e_rdata = '0; m_last = 1; m_valid = 1'b1;
        end
    endtask

    initial begin : model
        bit r, is_wr, done;
        int w, waited;
        forever begin
            m_edge(r);
            if (!r && m_valid && req != 2'b00) begin
                if (req == 2'b11) w = 1 - m_last;
                else              w = req[1] ? 1 : 0;
                m_last  = w;
                is_wr   = we[w];
                e_addr  = (w == 1) ? addr1 : addr0;
                e_wdata = (w == 1) ? wdata1 : wdata0;
                if (is_wr) e_wr = 1'b1; else e_rd = 1'b1;
                done = 1'b0;
                waited = 0;
                while (!done) begin
                    m_edge(r);
                    if (r) break;
                    if (is_wr) done = 1'b1;
                    else if (ram_rready) begin
                        e_rdata = ram_rdata;
                        done = 1'b1;
                    end else begin
                        waited++;
`ifdef RAM_ARB_TIMEOUT_EN
                        if (waited == TIMEOUT) begin
                            e_rdata = '1;
                            e_err = 1'b1;
                            done = 1'b1;
                        end
`endif
                    end
                end
                if (!r) begin
                    e_wr = 1'b0; e_rd = 1'b0;
                    e_ack = (w == 1) ? 2'b10 : 2'b01;
                    m_edge(r);
                    if (!r) begin
                        e_ack = 2'b00;
                        e_err = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_ack", ack, e_ack);
            chk("m_err", err, e_err);
            chk("m_ram_read", ram_read, e_rd);
            chk("m_ram_write", ram_write, e_wr);
            chk("m_rdata", rdata, e_rdata);
            if (e_wr) begin
                chk("m_waddr", ram_waddr, e_addr);
                chk("m_wdata", ram_wdata, e_wdata);
            end
            if (e_rd) chk("m_raddr", ram_raddr, e_addr);
        end
    end

    task automatic wait_ack(output logic [1:0] a);
        a = 2'b00;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                a = ack;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL ack_wait: no ack within 30 cycles, got %0h, expected nonzero", ack);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = 2'b00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [1:0] a;
        int cnt;
        reset = 1'b1; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        ram_rdata = '0; ram_rready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ack", ack, 2'b00);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_ram_read", ram_read, 1'b0);
        chk("rst_ram_write", ram_write, 1'b0);
        chk("rst_raddr", ram_raddr, 2'd0);
        chk("rst_waddr", ram_waddr, 2'd0);
        chk("rst_wdata", ram_wdata, 8'h00);

        // Write from requester 0, req dropped right after grant
        req = 2'b01; we = 2'b01; addr0 = 2'd2; wdata0 = 8'hA5;
        @(negedge clk);
        req = 2'b00;
        chk("wr_strobe", ram_write, 1'b1);
        chk("wr_waddr", ram_waddr, 2'd2);
        chk("wr_wdata", ram_wdata, 8'hA5);
        chk("wr_no_read", ram_read, 1'b0);
        @(negedge clk);
        chk("wr_ack", ack, 2'b01);
        @(negedge clk);
        chk("wr_ack_single", ack, 2'b00);

        // Read from requester 1, RAM answers in the 4th ram_read cycle
        req = 2'b10; we = 2'b00; addr1 = 2'd3;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req = 2'b00;
            if (ram_read) cnt++;
            if (i == 3) begin
                ram_rready = 1'b1;
                ram_rdata = 8'h3C;
            end
        end
        @(negedge clk);
        ram_rready = 1'b0; ram_rdata = 8'h55;
        chk("rd_hold_cycles", cnt, 4);
        chk("rd_ack", ack, 2'b10);
        chk("rd_rdata", rdata, 8'h3C);
        chk("rd_err", err, 1'b0);
        chk("rd_strobe_off", ram_read, 1'b0);
        // rready while idle must not disturb rdata
        @(negedge clk);
        ram_rready = 1'b1;
        repeat (2) @(negedge clk);
        ram_rready = 1'b0;
        chk("idle_rready_ignored", rdata, 8'h3C);

        // Both requesters writing continuously: grants alternate from requester 0
        do_reset();
        req = 2'b11; we = 2'b11; addr0 = 2'd1; addr1 = 2'd2; wdata0 = 8'h11; wdata1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            wait_ack(a);
            chk($sformatf("rr_grant%0d", k), a, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        req = 2'b00;
        repeat (6) @(negedge clk);

        // Reset during READ_WAIT aborts the read
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = 2'b00;
            chk("abort_read_hold", ram_read, 1'b1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_read_off", ram_read, 1'b0);
        chk("abort_no_ack", ack, 2'b00);
        chk("abort_write_off", ram_write, 1'b0);
        req = 2'b11; we = 2'b11;
        wait_ack(a);
        chk("abort_tie_winner", a, 2'b01);
        req = 2'b00;
        repeat (6) @(negedge clk);

        // Read with ram_rready never arriving
        do_reset();
        req = 2'b10; we = 2'b00; addr1 = 2'd2;
`ifdef RAM_ARB_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            req = 2'b00;
            if (!ram_read) break;
            cnt++;
        end
        chk("to_read_cycles", cnt, TIMEOUT);
        chk("to_ack", ack, 2'b10);
        chk("to_err", err, 1'b1);
        chk("to_rdata", rdata, 8'hFF);
        @(negedge clk);
        chk("to_err_clear", err, 1'b0);
`else
        repeat (40) begin
            @(negedge clk);
            req = 2'b00;
        end
        chk("nto_read_held", ram_read, 1'b1);
        chk("nto_err", err, 1'b0);
        chk("nto_no_ack", ack, 2'b00);
`endif
        do_reset();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
